prog_sequencer: RTL

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/prog_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: runs NUM_PROGS core programs back to back. Each program
// clears the register file, holds the core in reset while its start address
// settles, then releases it under a watchdog until the core reports done.
module prog_sequencer #(
    parameter int NUM_PROGS  = 3,
    parameter int PC_W       = 10,
    parameter int START0     = 0,
    parameter int START1     = 64,
    parameter int START2     = 128,
    parameter int CLR_CYC    = 2,
    parameter int SETTLE_CYC = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 go,
    input  logic                 abort,
    input  logic                 core_done,
    output logic                 core_reset,
    output logic [PC_W-1:0]      start_addr,
    output logic                 rf_clear,
    output logic [1:0]           prog_idx,
    output logic                 prog_done,
    output logic [15:0]          run_cycles,
    output logic [NUM_PROGS-1:0] timeout_flags,
    output logic                 busy,
    output logic                 all_done
);

    typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, RUN, DONE, FINISH} state_t;

    localparam logic [15:0] CLR_LAST = 16'(CLR_CYC - 1);
    localparam logic [15:0] SET_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [1:0]  IDX_LAST = 2'(NUM_PROGS - 1);

    function automatic logic [PC_W-1:0] start_of(input logic [1:0] idx);
        case (idx)
            2'd0:    start_of = PC_W'(START0);
            2'd1:    start_of = PC_W'(START1);
            default: start_of = PC_W'(START2);
        endcase
    endfunction

    function automatic logic [15:0] sat16(input logic [31:0] v);
        sat16 = (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
    endfunction

    state_t                state, state_n;
    logic [15:0]           cnt, cnt_n;      // CLEAR / LAUNCH dwell counter
    logic [31:0]           wdog, wdog_n;    // RUN-cycle watchdog
    logic [1:0]            idx_n;
    logic [PC_W-1:0]       addr_n;
    logic [15:0]           rc_n;
    logic [NUM_PROGS-1:0]  flags_n;
    logic                  core_reset_n, rf_clear_n, prog_done_n, busy_n, all_done_n;

    // Next-state and next-output logic; outputs are derived from the next
    // state so every output comes straight from a flop.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wdog_n  = wdog;
        idx_n   = prog_idx;
        addr_n  = start_addr;
        rc_n    = run_cycles;
        flags_n = timeout_flags;

        if (abort) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                    idx_n   = '0;
                    flags_n = '0;
                    rc_n    = '0;
                end
                CLEAR: if (cnt == CLR_LAST) begin
                    state_n = LAUNCH;
                    cnt_n   = '0;
                    // Load the address on LAUNCH entry; it then holds until
                    // the next program's LAUNCH.
                    addr_n  = start_of(prog_idx);
                end else begin
                    cnt_n = cnt + 16'd1;
                end
                LAUNCH: if (cnt == SET_LAST) begin
                    state_n = RUN;
                    wdog_n  = '0;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
                RUN: begin
                    if (wdog != '1) wdog_n = wdog + 32'd1;
                    // wdog==0 is the first RUN cycle: done may be stale there.
                    if (core_done && (wdog != '0)) begin
                        state_n = DONE;
                        rc_n    = sat16(wdog);
                    end else if (wdog == TO_LAST) begin
                        state_n           = DONE;
                        rc_n              = sat16(wdog);
                        flags_n[prog_idx] = 1'b1;
                    end
                end
                DONE: if (prog_idx == IDX_LAST) begin
                    state_n = FINISH;
                end else begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                    idx_n   = prog_idx + 2'd1;
                end
                FINISH: if (!go) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end

        core_reset_n = (state_n != RUN);
        rf_clear_n   = (state_n == CLEAR);
        prog_done_n  = (state_n == DONE);
        busy_n       = (state_n inside {CLEAR, LAUNCH, RUN, DONE});
        all_done_n   = (state_n == FINISH);
    end

    // State and output registers; reset forces core_reset high immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            wdog          <= '0;
            core_reset    <= 1'b1;
            rf_clear      <= 1'b0;
            prog_idx      <= '0;
            start_addr    <= PC_W'(START0);
            prog_done     <= 1'b0;
            run_cycles    <= '0;
            timeout_flags <= '0;
            busy          <= 1'b0;
            all_done      <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            wdog          <= wdog_n;
            core_reset    <= core_reset_n;
            rf_clear      <= rf_clear_n;
            prog_idx      <= idx_n;
            start_addr    <= addr_n;
            prog_done     <= prog_done_n;
            run_cycles    <= rc_n;
            timeout_flags <= flags_n;
            busy          <= busy_n;
            all_done      <= all_done_n;
        end
    end

endmodule
